// File: rtl/abs_diff_chk_pkg.sv
// rtl/abs_diff_chk_pkg.sv - shared state enum, default parameters and abs-difference helper
//
// Contents:
//   state_e   : sweep FSM states (IDLE, SWEEP, DRAIN, DONE)
//   DEF_OPW   : default operand width
//   DEF_OUTW  : default DUT output / error width
//   DEF_ET    : default error threshold
//   abs_diff  : unsigned |x-y| on 32-bit operands, used for both the exact
//               reference and the error calculation
package abs_diff_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_OPW  = 2;
  localparam int DEF_OUTW = 3;
  localparam int DEF_ET   = 3;

  // Callers zero-extend narrower operands, so the result never wraps.
  function automatic logic [31:0] abs_diff(input logic [31:0] x, input logic [31:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/abs_diff_err_acc.sv
// rtl/abs_diff_err_acc.sv - error accumulators: max error, violation count, first failing vector, optional error sum
//
// Optional feature: define ABS_DIFF_ERR_SUM_EN to add the err_sum output and its accumulator.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : clear all results (sweep start)
//   cmp_en      : compare vec against dut_out this cycle
//   vec         : {a,b} vector whose DUT result is on dut_out
//   dut_out     : approximate DUT result
//   max_err     : largest error seen
//   viol_cnt    : saturating count of errors above ET
//   first_fail  : vector of the first violation, 0 if none
//   err_sum     : saturating sum of errors (ABS_DIFF_ERR_SUM_EN only)
module abs_diff_err_acc
  import abs_diff_chk_pkg::*;
#(
  parameter int OPW  = DEF_OPW,
  parameter int OUTW = DEF_OUTW,
  parameter int ET   = DEF_ET
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                cmp_en,
  input  logic [2*OPW-1:0]    vec,
  input  logic [OUTW-1:0]     dut_out,
  output logic [OUTW-1:0]     max_err,
  output logic [2*OPW:0]      viol_cnt,
  output logic [2*OPW-1:0]    first_fail
`ifdef ABS_DIFF_ERR_SUM_EN
  ,
  output logic [OUTW+2*OPW-1:0] err_sum
`endif
);

  localparam logic [31:0] OUT_MASK = (32'd1 << OUTW) - 32'd1;
  localparam logic [31:0] ET_U     = 32'(ET);

  logic [31:0]     exact_w;
  logic [31:0]     exact_m;
  logic [31:0]     err_w;
  logic [OUTW-1:0] err;
  logic            viol;

  always_comb begin
    exact_w = abs_diff({{(32-OPW){1'b0}}, vec[2*OPW-1:OPW]},
                       {{(32-OPW){1'b0}}, vec[OPW-1:0]});
    // Reference is truncated to the DUT output width before the error is taken.
    exact_m = exact_w & OUT_MASK;
    err_w   = abs_diff(exact_m, {{(32-OUTW){1'b0}}, dut_out});
    err     = err_w[OUTW-1:0];
    viol    = (err_w > ET_U);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_err    <= '0;
      viol_cnt   <= '0;
      first_fail <= '0;
    end else if (clr) begin
      max_err    <= '0;
      viol_cnt   <= '0;
      first_fail <= '0;
    end else if (cmp_en) begin
      if (err > max_err) begin
        max_err <= err;
      end
      if (viol) begin
        if (viol_cnt == '0) begin
          first_fail <= vec;
        end
        if (viol_cnt != '1) begin
          viol_cnt <= viol_cnt + 1'b1;
        end
      end
    end
  end

`ifdef ABS_DIFF_ERR_SUM_EN
  localparam int SW = OUTW + 2*OPW;

  logic [SW:0] sum_next;

  always_comb begin
    sum_next = {1'b0, err_sum} + {{(SW+1-OUTW){1'b0}}, err};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sum <= '0;
    end else if (clr) begin
      err_sum <= '0;
    end else if (cmp_en) begin
      err_sum <= sum_next[SW] ? {SW{1'b1}} : sum_next[SW-1:0];
    end
  end
`endif

endmodule

// File: rtl/abs_diff_err_checker.sv
// rtl/abs_diff_err_checker.sv - exhaustive sweep checker for a combinational approximate |a-b| unit
//
// Optional feature: define ABS_DIFF_ERR_SUM_EN to add the err_sum output.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : pulse to begin a sweep (accepted in IDLE and DONE)
//   stim_a, stim_b  : registered operands to the DUT, 0 outside SWEEP
//   dut_out         : DUT result for the previous cycle's operands
//   busy            : high in SWEEP and DRAIN
//   done            : high in DONE
//   max_err         : maximum |exact-dut_out|
//   viol_cnt        : number of vectors with error above ET (saturating)
//   first_fail      : {a,b} of first violation, 0 if none
//   pass            : in DONE, high when no violation was seen
//   err_sum         : saturating sum of errors (ABS_DIFF_ERR_SUM_EN only)
module abs_diff_err_checker
  import abs_diff_chk_pkg::*;
#(
  parameter int OPW  = DEF_OPW,
  parameter int OUTW = DEF_OUTW,
  parameter int ET   = DEF_ET
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [OPW-1:0]      stim_a,
  output logic [OPW-1:0]      stim_b,
  input  logic [OUTW-1:0]     dut_out,
  output logic                busy,
  output logic                done,
  output logic [OUTW-1:0]     max_err,
  output logic [2*OPW:0]      viol_cnt,
  output logic [2*OPW-1:0]    first_fail,
  output logic                pass
`ifdef ABS_DIFF_ERR_SUM_EN
  ,
  output logic [OUTW+2*OPW-1:0] err_sum
`endif
);

  localparam int KW = 2*OPW;

  state_e        state;
  logic [KW-1:0] k;
  logic [KW-1:0] stim_q;
  logic [KW-1:0] vec_q;
  logic          cmp_vld;
  logic          clr;

  // Start is honoured only when no sweep is running.
  assign clr = start && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      k       <= '0;
      stim_q  <= '0;
      vec_q   <= '0;
      cmp_vld <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // The DUT answers one cycle later, so remember what was driven.
      vec_q   <= stim_q;
      cmp_vld <= (state == ST_SWEEP);
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state  <= ST_SWEEP;
            k      <= '0;
            stim_q <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
          end
        end
        ST_SWEEP: begin
          if (k == '1) begin
            state  <= ST_DRAIN;
            stim_q <= '0;
          end else begin
            k      <= k + 1'b1;
            stim_q <= k + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Last vector is compared in this cycle.
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign stim_a = stim_q[KW-1:OPW];
  assign stim_b = stim_q[OPW-1:0];
  assign pass   = done && (viol_cnt == '0);

  abs_diff_err_acc #(
    .OPW  (OPW),
    .OUTW (OUTW),
    .ET   (ET)
  ) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .cmp_en     (cmp_vld),
    .vec        (vec_q),
    .dut_out    (dut_out),
    .max_err    (max_err),
    .viol_cnt   (viol_cnt),
    .first_fail (first_fail)
`ifdef ABS_DIFF_ERR_SUM_EN
    ,
    .err_sum    (err_sum)
`endif
  );

endmodule

// File: tb/tb_abs_diff_err_checker.sv
// tb/tb_abs_diff_err_checker.sv - self-checking bench for abs_diff_err_checker
module tb_abs_diff_err_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] stim_a;
  logic [1:0] stim_b;
  logic [2:0] dut_out;
  logic       busy;
  logic       done;
  logic [2:0] max_err;
  logic [4:0] viol_cnt;
  logic [3:0] first_fail;
  logic       pass;
`ifdef ABS_DIFF_ERR_SUM_EN
  logic [6:0] err_sum;
`endif

  abs_diff_err_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stim_a     (stim_a),
    .stim_b     (stim_b),
    .dut_out    (dut_out),
    .busy       (busy),
    .done       (done),
    .max_err    (max_err),
    .viol_cnt   (viol_cnt),
    .first_fail (first_fail),
    .pass       (pass)
`ifdef ABS_DIFF_ERR_SUM_EN
    ,
    .err_sum    (err_sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Modelled approximate unit: 0 exact, 1 stuck 0, 2 stuck 7,
  // 3 exact except 5 at {a,b}=1001, 4 random lookup table.
  int mode;
  int rand_tab [16];
  int n_cmp;
  int n_fail;

  function automatic int dut_val(input int m, input int v);
    int a;
    int b;
    int ex;
    a  = v / 4;
    b  = v % 4;
    ex = (a > b) ? a - b : b - a;
    case (m)
      1:       return 0;
      2:       return 7;
      3:       return (v == 9) ? 5 : ex;
      4:       return rand_tab[v];
      default: return ex;
    endcase
  endfunction

  // One-cycle-latency DUT: result reflects the operands of the previous cycle.
  always @(posedge clk) begin
    dut_out <= 3'(dut_val(mode, int'({stim_a, stim_b})));
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Whole-sweep expectation straight from the error rules.
  task automatic model(input int m, output int mx, output int viol, output int ff,
                       output int ps, output int sum);
    int e;
    mx = 0; viol = 0; ff = 0; sum = 0;
    for (int v = 0; v < 16; v++) begin
      int a;
      int b;
      int ex;
      int d;
      a  = v / 4;
      b  = v % 4;
      ex = (a > b) ? a - b : b - a;
      d  = dut_val(m, v);
      e  = (ex > d) ? ex - d : d - ex;
      if (e > mx) mx = e;
      if (e > 3) begin
        if (viol == 0) ff = v;
        if (viol < 31) viol++;
      end
      sum = sum + e;
    end
    if (sum > 127) sum = 127;
    ps = (viol == 0) ? 1 : 0;
  endtask

  task automatic check_results(input string tag, input int mx, input int viol,
                               input int ff, input int ps, input int sum);
    check({tag, ".max_err"}, int'(max_err), mx);
    check({tag, ".viol_cnt"}, int'(viol_cnt), viol);
    check({tag, ".first_fail"}, int'(first_fail), ff);
    check({tag, ".pass"}, int'(pass), ps);
`ifdef ABS_DIFF_ERR_SUM_EN
    check({tag, ".err_sum"}, int'(err_sum), sum);
`else
    if (sum < 0) $display("negative sum");
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, int'(busy), 0);
    check({tag, ".done"}, int'(done), 0);
    check({tag, ".stim"}, int'({stim_a, stim_b}), 0);
    check({tag, ".max_err"}, int'(max_err), 0);
    check({tag, ".viol_cnt"}, int'(viol_cnt), 0);
    check({tag, ".first_fail"}, int'(first_fail), 0);
    check({tag, ".pass"}, int'(pass), 0);
`ifdef ABS_DIFF_ERR_SUM_EN
    check({tag, ".err_sum"}, int'(err_sum), 0);
`endif
  endtask

  // Pulse start, follow the sweep, check its length and stimulus order.
  task automatic run_sweep(input string tag, input bit extra_starts);
    int cycles;
    int stim_bad;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles   = 0;
    stim_bad = 0;
    while (busy && cycles < 100) begin
      if (int'({stim_a, stim_b}) != ((cycles < 16) ? cycles : 0)) stim_bad++;
      start = (extra_starts && (cycles == 5 || cycles == 16)) ? 1'b1 : 1'b0;
      cycles++;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, ".busy_cycles"}, cycles, 17);
    check({tag, ".stim_seq_errors"}, stim_bad, 0);
    check({tag, ".done"}, int'(done), 1);
  endtask

  typedef struct {
    string name;
    int    mode;
    int    mx;
    int    viol;
    int    ff;
    int    ps;
    int    sum;
  } vec_t;

  vec_t tab [4];

  initial begin
    int mx;
    int viol;
    int ff;
    int ps;
    int sum;

    tab[0] = '{"exact",   0, 0, 0,  0, 1, 0};
    tab[1] = '{"stuck0",  1, 3, 0,  0, 1, 20};
    tab[2] = '{"stuck7",  2, 7, 16, 0, 0, 92};
    tab[3] = '{"one_bad", 3, 4, 1,  9, 0, 4};

    n_cmp  = 0;
    n_fail = 0;
    mode   = 0;
    start  = 1'b0;
    rst_n  = 1'b0;
    for (int i = 0; i < 16; i++) rand_tab[i] = 0;

    repeat (3) @(negedge clk);
    check_all_zero("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("idle");

    for (int i = 0; i < 4; i++) begin
      mode = tab[i].mode;
      run_sweep(tab[i].name, 1'b0);
      check_results(tab[i].name, tab[i].mx, tab[i].viol, tab[i].ff, tab[i].ps, tab[i].sum);
    end

    // Results must not move in DONE while dut_out changes.
    mode = 0;
    repeat (4) @(negedge clk);
    check("done_hold.stim", int'({stim_a, stim_b}), 0);
    check_results("done_hold", 4, 1, 9, 0, 4);

    // Abort mid-sweep with stuck-7, then a rerun with ignored start pulses.
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_abort.busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    check_all_zero("abort_hold");
    rst_n = 1'b1;
    @(negedge clk);
    mode = 3;
    run_sweep("rerun", 1'b1);
    check_results("rerun", 4, 1, 9, 0, 4);

    // Random approximate units against the behavioural model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) rand_tab[i] = int'($urandom_range(0, 7));
      mode = 4;
      model(4, mx, viol, ff, ps, sum);
      run_sweep($sformatf("rand%0d", r), r[0]);
      check_results($sformatf("rand%0d", r), mx, viol, ff, ps, sum);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
